// File: rtl/guess_tracker_if.sv
// Bundles the cursor/referee signals of the guess tracker.
// Referee handshake (valid/ack):
//   - guess_valid rises with a new one-hot guess on sing_guess.
//   - guess_valid and sing_guess stay stable until a cycle with guess_ack=1.
//   - hit is sampled in that same cycle.
//   - guess_valid falls on the following edge.
//   - Outside a handshake, guess_ack is ignored.
//   - If guess_valid drops without an ack (phase fall or reset), the guess is cancelled.
interface guess_tracker_if #(
    parameter int N_FIELDS = 4,
    parameter int CNT_W    = 5
);
    localparam int CELLS = 7 * N_FIELDS;

    // cursor / control side
    logic                sel;
    logic                sw;
    logic                phase;
    logic [7:0]          seg;
    logic [N_FIELDS-1:0] an;

    // referee side
    logic                guess_ack;
    logic                hit;

    // tracker results
    logic [CELLS-1:0]    pguess;
    logic [CELLS-1:0]    phits;
    logic [CELLS-1:0]    sing_guess;
    logic                guess_valid;
    logic                dup_err;
    logic [CNT_W-1:0]    guess_count;
    logic                done;
    logic [1:0]          dbg_state;

    modport master (
        output sel, sw, phase, seg, an, guess_ack, hit,
        input  pguess, phits, sing_guess, guess_valid, dup_err,
               guess_count, done, dbg_state
    );

    modport slave (
        input  sel, sw, phase, seg, an, guess_ack, hit,
        output pguess, phits, sing_guess, guess_valid, dup_err,
               guess_count, done, dbg_state
    );
endinterface

// File: rtl/guess_tracker.sv
// Game-phase guess tracker.
// Decodes the active-low cursor (field select + segment) into a cell index.
// Records each confirmed guess and hands it to the referee over valid/ack.
// Accumulates the guessed and hit cell maps and counts accepted guesses.
// Raises done once the guess limit is reached.
module guess_tracker #(
    parameter int N_FIELDS     = 4,
    parameter int MAX_GUESSES  = 20,
    parameter int ALLOW_REPEAT = 0,
    parameter int CNT_W        = 5
) (
    input  logic           clk,
    input  logic           rst,
    guess_tracker_if.slave bus
);
    localparam int CELLS = 7 * N_FIELDS;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_GUESSES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_ACK = 2'd1;
    localparam logic [1:0] S_DONE     = 2'd2;

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    logic [1:0]       r_state;
    logic             r_sel_q;
    logic             r_phase_q;
    logic [CELLS-1:0] r_pguess;
    logic [CELLS-1:0] r_phits;
    logic [CELLS-1:0] r_sing;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_dup;
    logic [CNT_W-1:0] r_count;
    logic             r_done;

    // ---------------------------------------------------------------
    // Combinational signals
    // ---------------------------------------------------------------
    logic [N_FIELDS-1:0] w_an_n;
    logic                w_an_ok;
    logic [6:0]          w_seg_n;
    logic                w_seg_ok;
    logic [2:0]          w_off;
    logic [IDX_W-1:0]    w_base;
    logic [IDX_W-1:0]    w_idx;
    logic [CELLS-1:0]    w_onehot;
    logic                w_cell_ok;
    logic                w_sel_event;
    logic                w_new_game;
    logic                w_try;
    logic                w_is_dup;
    logic                w_issue;
    logic                w_do_ack;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_to_done;

    // Work on active-high copies of the active-low cursor.
    assign w_an_n  = ~bus.an;
    assign w_seg_n = ~bus.seg[6:0];

    // Exactly one field may be selected.
    assign w_an_ok = (w_an_n != '0) && ((w_an_n & (w_an_n - N_FIELDS'(1))) == '0);

    // A press counts only on the rising edge of the debounced button.
    assign w_sel_event = bus.sel & ~r_sel_q;

    // A falling phase starts a new game.
    assign w_new_game = r_phase_q & ~bus.phase;

    // Base cell of the selected field (7 cells per field).
    always_comb begin
        w_base = '0;
        for (int f = 0; f < N_FIELDS; f++) begin
            if (w_an_n[f]) begin
                w_base = IDX_W'(7 * f);
            end
        end
    end

    // Map the single lit segment to its cell offset inside the field.
    // The one-hot check is built into the case: any other pattern is rejected.
    always_comb begin
        w_off    = 3'd0;
        w_seg_ok = 1'b1;
        case (w_seg_n)
            7'b0000001: w_off = 3'd1;
            7'b0000010: w_off = 3'd0;
            7'b0000100: w_off = 3'd4;
            7'b0001000: w_off = 3'd3;
            7'b0010000: w_off = 3'd2;
            7'b0100000: w_off = 3'd6;
            7'b1000000: w_off = 3'd5;
            default:    w_seg_ok = 1'b0;
        endcase
    end

    // The decimal point must be dark (seg[7] high) for a valid cell.
    assign w_cell_ok = w_an_ok & w_seg_ok & bus.seg[7];
    assign w_idx     = w_base + IDX_W'(w_off);

    // One-hot image of the decoded cell.
    always_comb begin
        w_onehot        = '0;
        w_onehot[w_idx] = 1'b1;
    end

    // Decide what a press does while idle.
    assign w_try    = (r_state == S_IDLE) && w_sel_event && bus.phase
                      && !bus.sw && w_cell_ok && !w_new_game;
    assign w_is_dup = w_try && r_pguess[w_idx] && (ALLOW_REPEAT == 0);
    assign w_issue  = w_try && !w_is_dup;

    // Referee acceptance.
    // A new game in the same cycle wins over the ack.
    assign w_do_ack    = (r_state == S_WAIT_ACK) && bus.guess_ack && !w_new_game;
    assign w_count_nxt = (r_count < MAX_CNT) ? (r_count + CNT_W'(1)) : r_count;
    assign w_to_done   = w_do_ack && (w_count_nxt == MAX_CNT);

    // ---------------------------------------------------------------
    // Sequential logic
    // ---------------------------------------------------------------

    // Delayed copies of sel and phase for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel_q   <= 1'b0;
            r_phase_q <= 1'b0;
        end else begin
            r_sel_q   <= bus.sel;
            r_phase_q <= bus.phase;
        end
    end

    // Control FSM: IDLE -> WAIT_ACK -> IDLE or DONE; phase fall returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (w_new_game) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_do_ack) begin
                        r_state <= w_to_done ? S_DONE : S_IDLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Issue side.
    // Record the guess, present it one-hot, and hold it until the ack.
    // sing_guess keeps its value after the ack so the display can show it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pguess <= '0;
            r_sing   <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
        end else if (w_new_game) begin
            r_pguess <= '0;
            r_sing   <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
        end else if (w_issue) begin
            r_pguess <= r_pguess | w_onehot;
            r_sing   <= w_onehot;
            r_idx    <= w_idx;
            r_valid  <= 1'b1;
        end else if (w_do_ack) begin
            r_valid  <= 1'b0;
        end
    end

    // Result side: latch hit, count accepted guesses (saturating), flag game over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phits <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (w_new_game) begin
            r_phits <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (w_do_ack) begin
            if (bus.hit) begin
                r_phits[r_idx] <= 1'b1;
            end
            r_count <= w_count_nxt;
            if (w_to_done) begin
                r_done <= 1'b1;
            end
        end
    end

    // Single-cycle duplicate-guess pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dup <= 1'b0;
        end else begin
            r_dup <= w_is_dup;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.pguess      = r_pguess;
    assign bus.phits       = r_phits;
    assign bus.sing_guess  = r_sing;
    assign bus.guess_valid = r_valid;
    assign bus.dup_err     = r_dup;
    assign bus.guess_count = r_count;
    assign bus.done        = r_done;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_guess_tracker.sv
// Testbench for guess_tracker.
// Randomised cursor/referee stimulus is checked against a transaction-level game model.
// The model's expected events (guess issued, duplicate, handshake end) are queued.
// A monitor compares those queued events against what the DUT presents.
module tb_guess_tracker;
    localparam int N_FIELDS     = 4;
    localparam int MAX_GUESSES  = 6;
    localparam int ALLOW_REPEAT = 0;
    localparam int CNT_W        = 5;
    localparam int CELLS        = 7 * N_FIELDS;

    localparam int EV_GUESS = 0;
    localparam int EV_DUP   = 1;
    localparam int EV_DROP  = 2;

    typedef struct packed {
        logic [1:0]       kind;
        logic [31:0]      cyc;
        logic [CELLS-1:0] sing;
        logic [CELLS-1:0] pg;
        logic [CELLS-1:0] ph;
        logic [CNT_W-1:0] cnt;
        logic             dn;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // cell offset inside a field for each lit segment bit 0..6
    int off_tab[7] = '{1, 0, 4, 3, 2, 6, 5};

    // game model
    logic [CELLS-1:0] m_pg, m_ph, m_sing;
    int               m_cnt;
    int               m_idx;
    logic             m_wait, m_done, m_phase;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    guess_tracker_if #(.N_FIELDS(N_FIELDS), .CNT_W(CNT_W)) bus ();

    guess_tracker #(
        .N_FIELDS    (N_FIELDS),
        .MAX_GUESSES (MAX_GUESSES),
        .ALLOW_REPEAT(ALLOW_REPEAT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_pg   = '0;
        m_ph   = '0;
        m_sing = '0;
        m_cnt  = 0;
        m_idx  = 0;
        m_wait = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic push_exp(input int kind, input int at);
        exp_t e;
        e.kind = 2'(kind);
        e.cyc  = 32'(at);
        e.sing = m_sing;
        e.pg   = m_pg;
        e.ph   = m_ph;
        e.cnt  = CNT_W'(m_cnt);
        e.dn   = m_done;
        exp_q.push_back(e);
    endtask

    // Reference decode: the single dark field and the single lit segment pick the cell.
    function automatic logic decode(input logic [N_FIELDS-1:0] a, input logic [7:0] s,
                                    output int idx);
        int nf, f, ns, b;
        nf = 0; f = 0; ns = 0; b = 0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if (!a[i]) begin nf++; f = i; end
        end
        for (int i = 0; i < 7; i++) begin
            if (!s[i]) begin ns++; b = i; end
        end
        idx = 7 * f + off_tab[b];
        return (nf == 1) && (ns == 1) && s[7];
    endfunction

    // Referee accepts the pending guess (model side).
    task automatic model_ack(input logic h, input int at);
        if (h) m_ph[m_idx] = 1'b1;
        if (m_cnt < MAX_GUESSES) m_cnt++;
        m_wait = 1'b0;
        if (m_cnt == MAX_GUESSES) m_done = 1'b1;
        push_exp(EV_DROP, at);
    endtask

    task automatic check_state(input string nm);
        chk({nm, "_pguess"}, 64'(bus.pguess), 64'(m_pg));
        chk({nm, "_phits"}, 64'(bus.phits), 64'(m_ph));
        chk({nm, "_sing"}, 64'(bus.sing_guess), 64'(m_sing));
        chk({nm, "_valid"}, 64'(bus.guess_valid), 64'(m_wait));
        chk({nm, "_count"}, 64'(bus.guess_count), 64'(m_cnt));
        chk({nm, "_done"}, 64'(bus.done), 64'(m_done));
        chk({nm, "_dup"}, 64'(bus.dup_err), 64'd0);
    endtask

    // ---------------- driver tasks ----------------
    // Press the button on cursor (a, s).
    // Hold it for 'hold' cycles, then release.
    // With with_ack, the referee acks in the same cycle as the press edge.
    task automatic press(input logic [N_FIELDS-1:0] a, input logic [7:0] s, input logic swv,
                         input int hold, input logic with_ack, input logic hv);
        int  idx;
        logic ok;
        ok = decode(a, s, idx);
        bus.an  = a;
        bus.seg = s;
        bus.sw  = swv;
        bus.sel = 1'b1;
        if (with_ack) begin
            bus.guess_ack = 1'b1;
            bus.hit       = hv;
        end
        if (with_ack && m_wait) begin
            model_ack(hv, cyc + 1);          // press lands in WAIT_ACK: dropped
        end else if (!m_wait && !m_done && m_phase && !swv && ok) begin
            if (m_pg[idx] && ALLOW_REPEAT == 0) begin
                push_exp(EV_DUP, cyc + 1);
            end else begin
                m_pg[idx]   = 1'b1;
                m_sing      = '0;
                m_sing[idx] = 1'b1;
                m_idx       = idx;
                m_wait      = 1'b1;
                push_exp(EV_GUESS, cyc + 1);
            end
        end
        tick();
        bus.guess_ack = 1'b0;
        for (int i = 1; i < hold; i++) tick();
        bus.sel = 1'b0;
        bus.sw  = 1'b0;
        tick();
    endtask

    task automatic ack(input logic hv);
        bus.guess_ack = 1'b1;
        bus.hit       = hv;
        if (m_wait) model_ack(hv, cyc + 1);
        tick();
        bus.guess_ack = 1'b0;
        tick();
    endtask

    task automatic phase_drop(input logic with_ack);
        logic was_wait;
        was_wait      = m_wait;
        bus.phase     = 1'b0;
        bus.guess_ack = with_ack;
        bus.hit       = 1'b1;
        model_clear();
        if (was_wait) push_exp(EV_DROP, cyc + 1);
        m_phase = 1'b0;
        tick();
        bus.guess_ack = 1'b0;
        tick();
        bus.phase = 1'b1;
        m_phase   = 1'b1;
        tick();
    endtask

    task automatic reset_mid();
        logic was_wait;
        was_wait = m_wait;
        rst      = 1'b0;
        model_clear();
        if (was_wait) push_exp(EV_DROP, cyc);
        tick();
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic rand_press(input logic with_ack);
        logic [N_FIELDS-1:0] a;
        logic [7:0]          s;
        a = '1;
        a[$urandom_range(0, N_FIELDS - 1)] = 1'b0;
        if ($urandom_range(0, 9) == 0) a = N_FIELDS'($urandom);
        s = 8'hFF;
        s[$urandom_range(0, 6)] = 1'b0;
        if ($urandom_range(0, 9) == 0) s = 8'($urandom);
        press(a, s, ($urandom_range(0, 9) == 0), $urandom_range(1, 4), with_ack,
              1'($urandom_range(0, 1)));
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic prev_v;
        int   kind;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            kind = -1;
            if (bus.dup_err === 1'b1) kind = EV_DUP;
            else if (bus.guess_valid === 1'b1 && !prev_v) kind = EV_GUESS;
            else if (bus.guess_valid !== 1'b1 && prev_v) kind = EV_DROP;
            prev_v = (bus.guess_valid === 1'b1);
            if (kind >= 0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got event kind %0d at cycle %0d, expected none",
                             kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_kind", 64'(kind), 64'(e.kind));
                    chk("ev_cycle", 64'(cyc), 64'(e.cyc));
                    chk("ev_sing", 64'(bus.sing_guess), 64'(e.sing));
                    chk("ev_pguess", 64'(bus.pguess), 64'(e.pg));
                    chk("ev_phits", 64'(bus.phits), 64'(e.ph));
                    chk("ev_count", 64'(bus.guess_count), 64'(e.cnt));
                    chk("ev_done", 64'(bus.done), 64'(e.dn));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.sel       = 1'b0;
        bus.sw        = 1'b0;
        bus.phase     = 1'b0;
        bus.seg       = 8'hFF;
        bus.an        = '1;
        bus.guess_ack = 1'b0;
        bus.hit       = 1'b0;
        model_clear();
        m_phase = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        rst = 1'b1;
        tick();
        bus.phase = 1'b1;
        m_phase   = 1'b1;
        tick();
        tick();

        // first guess: field 0, segment bit0 -> cell 1, then a hit
        press(4'b1110, 8'hFE, 1'b0, 1, 1'b0, 1'b0);
        check_state("first_guess");
        ack(1'b1);
        check_state("first_ack");

        // held button: exactly one guess, cell 13
        press(4'b1101, 8'hDF, 1'b0, 10, 1'b0, 1'b0);
        check_state("held_sel");
        ack(1'b0);

        // repeat of cell 13: duplicate pulse, nothing issued
        press(4'b1101, 8'hDF, 1'b0, 1, 1'b0, 1'b0);
        check_state("dup");

        // invalid cursors and sw=1 are ignored
        press(4'b1100, 8'hFE, 1'b0, 1, 1'b0, 1'b0);
        press(4'b1110, 8'hFC, 1'b0, 1, 1'b0, 1'b0);
        press(4'b1110, 8'h7E, 1'b0, 1, 1'b0, 1'b0);
        press(4'b1011, 8'hF7, 1'b1, 1, 1'b0, 1'b0);
        check_state("ignored");

        // cell 17, then a press that coincides with the ack is dropped
        press(4'b1011, 8'hF7, 1'b0, 1, 1'b0, 1'b0);
        press(4'b0111, 8'hFE, 1'b0, 1, 1'b1, 1'b1);
        check_state("sel_with_ack");

        // fill up to the limit: cells 22, 0, 4
        press(4'b0111, 8'hFE, 1'b0, 1, 1'b0, 1'b0);
        ack(1'b0);
        press(4'b1110, 8'hFD, 1'b0, 1, 1'b0, 1'b0);
        ack(1'b1);
        press(4'b1110, 8'hFB, 1'b0, 1, 1'b0, 1'b0);
        ack(1'b1);
        check_state("limit");
        press(4'b1110, 8'hBF, 1'b0, 1, 1'b0, 1'b0);
        ack(1'b1);
        check_state("after_done");

        // new game, then phase drop with a same-cycle ack, then reset mid-handshake
        phase_drop(1'b0);
        check_state("new_game");
        press(4'b1110, 8'hFE, 1'b0, 1, 1'b0, 1'b0);
        phase_drop(1'b1);
        check_state("drop_with_ack");
        press(4'b1110, 8'hEF, 1'b0, 1, 1'b0, 1'b0);
        reset_mid();
        check_state("reset_mid");

        // randomised play
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50)      rand_press(1'b0);
            else if (r < 80) ack(1'($urandom_range(0, 1)));
            else if (r < 87) phase_drop(1'($urandom_range(0, 1)));
            else if (r < 91) reset_mid();
            else             rand_press(1'b1);
            if (n % 10 == 0) check_state("rand");
        end

        repeat (4) tick();
        check_state("final");
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
